// File: rtl/en_pulse_sequencer.sv
// Enable-strobe source: settle after reset, then ON bursts of a latched length, each followed by a fixed gap.
// Optional embedded concurrent checks when EN_PULSE_SEQ_SVA_EN is defined.
//
// state  | meaning
// SETTLE | post-reset hold, counting SETTLE_CYC cycles before ready
// IDLE   | ready=1, waiting for start
// ON     | en=1, on_cnt counting toward the latched length
// GAP    | en=0, busy=1 for GAP_CYC cycles after every burst
module en_pulse_sequencer #(
    parameter int CNT_W      = 8,
    parameter int SETTLE_CYC = 4,
    parameter int GAP_CYC    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] on_len,
    output logic             en,
    output logic             busy,
    output logic             ready,
    output logic             done,
    output logic [CNT_W-1:0] on_cnt
);

    localparam logic [1:0] S_SETTLE = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(GAP_CYC - 1);

    logic [1:0]          state_q,  state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [GAP_W-1:0]    gap_q,    gap_d;
    logic [CNT_W-1:0]    len_q,    len_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                en_q,     en_d;
    logic                busy_q,   busy_d;
    logic                ready_q,  ready_d;
    logic                done_q,   done_d;

    // All outputs are computed for the next cycle so they come straight from flops.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        gap_d    = gap_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        en_d     = 1'b0;
        busy_d   = 1'b0;
        ready_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            S_IDLE: begin
                if (start) begin
                    state_d = S_ON;
                    len_d   = (on_len == '0) ? CNT_W'(1) : on_len;
                    cnt_d   = CNT_W'(1);
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_ON: begin
                busy_d = 1'b1;
                // Abort takes priority, even on the final cycle, so an abort never reports done.
                if (stop) begin
                    state_d = S_GAP;
                    gap_d   = GAP_LAST;
                end else if (cnt_q == len_q) begin
                    state_d = S_GAP;
                    gap_d   = GAP_LAST;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    en_d  = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    gap_d  = gap_q - GAP_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d  = S_SETTLE;
                settle_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_SETTLE;
            settle_q <= '0;
            gap_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            gap_q    <= gap_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign en     = en_q;
    assign busy   = busy_q;
    assign ready  = ready_q;
    assign done   = done_q;
    assign on_cnt = cnt_q;

`ifdef EN_PULSE_SEQ_SVA_EN
    // Length of the current en run, excluding the present cycle.
    logic [CNT_W:0] sva_run_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sva_run_q <= '0;
        end else if (en_q) begin
            sva_run_q <= sva_run_q + (CNT_W+1)'(1);
        end else begin
            sva_run_q <= '0;
        end
    end

    a_en_busy: assert property (@(posedge clk) disable iff (!rst) en_q |-> busy_q)
        $info("a_en_busy held at %0t", $time);
    else
        $error("a_en_busy violated at %0t", $time);

    a_done_not_en: assert property (@(posedge clk) disable iff (!rst) done_q |-> !en_q)
        $info("a_done_not_en held at %0t", $time);
    else
        $error("a_done_not_en violated at %0t", $time);

    a_rise_after_start: assert property (@(posedge clk) disable iff (!rst)
        $rose(en_q) |-> $past(start && ready_q))
        $info("a_rise_after_start held at %0t", $time);
    else
        $error("a_rise_after_start violated at %0t", $time);

    a_en_len: assert property (@(posedge clk) disable iff (!rst)
        en_q |-> (sva_run_q < {1'b0, len_q}))
        $info("a_en_len held at %0t", $time);
    else
        $error("a_en_len violated at %0t", $time);

    a_ready_idle: assert property (@(posedge clk) disable iff (!rst) ready_q |-> !busy_q)
        $info("a_ready_idle held at %0t", $time);
    else
        $error("a_ready_idle violated at %0t", $time);
`else
    // Checks not compiled; functional logic above is unchanged.
`endif

endmodule

// File: tb/tb_en_pulse_sequencer.sv
// Directed bench for en_pulse_sequencer: expected outputs queued per step, compared one cycle later.
module tb_en_pulse_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] on_len;
    logic       en;
    logic       busy;
    logic       ready;
    logic       done;
    logic [7:0] on_cnt;

    logic [11:0] exp_q[$];
    string       tag_q[$];
    int          n_cmp;
    int          n_err;

    en_pulse_sequencer #(.CNT_W(8), .SETTLE_CYC(4), .GAP_CYC(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .on_len (on_len),
        .en     (en),
        .busy   (busy),
        .ready  (ready),
        .done   (done),
        .on_cnt (on_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs for one cycle, queue the outputs expected after the next edge, then check them.
    task automatic step(input string tag, input logic st, input logic sp, input logic [7:0] len,
                        input logic e_en, input logic e_busy, input logic e_ready,
                        input logic e_done, input logic [7:0] e_cnt);
        logic [11:0] exp_v;
        logic [11:0] obs_v;
        string       t;
        exp_q.push_back({e_en, e_busy, e_ready, e_done, e_cnt});
        tag_q.push_back(tag);
        start  = st;
        stop   = sp;
        on_len = len;
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        t     = tag_q.pop_front();
        obs_v = {en, busy, ready, done, on_cnt};
        n_cmp++;
        assert (obs_v === exp_v) else begin
            n_err++;
            $error("FAIL %s observed en/busy/ready/done/cnt=%h expected=%h", t, obs_v, exp_v);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        on_len = 8'd0;
        #1;

        // 1: reset held three cycles, then settle with start asserted (ignored)
        for (int i = 0; i < 3; i++) step("in_reset", 1'b1, 1'b0, 8'd5, 0, 0, 0, 0, 8'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step("settle", 1'b1, 1'b1, 8'd5, 0, 0, 0, 0, 8'd0);
        step("settle_ready", 1'b1, 1'b0, 8'd5, 0, 0, 1, 0, 8'd0);
        step("idle_hold", 1'b0, 1'b1, 8'd5, 0, 0, 1, 0, 8'd0);

        // 2: five-cycle burst, start/on_len changes during ON and GAP ignored
        step("b5_first", 1'b1, 1'b0, 8'd5, 1, 1, 0, 0, 8'd1);
        for (int i = 2; i <= 5; i++) step("b5_on", 1'b1, 1'b0, 8'd9, 1, 1, 0, 0, 8'(i));
        step("b5_done", 1'b1, 1'b0, 8'd9, 0, 1, 0, 1, 8'd5);
        step("b5_gap2", 1'b1, 1'b0, 8'd9, 0, 1, 0, 0, 8'd5);
        step("b5_idle", 1'b0, 1'b0, 8'd9, 0, 0, 1, 0, 8'd5);

        // 3: zero length behaves as one cycle
        step("b0_first", 1'b1, 1'b0, 8'd0, 1, 1, 0, 0, 8'd1);
        step("b0_done", 1'b0, 1'b0, 8'd0, 0, 1, 0, 1, 8'd1);
        step("b0_gap2", 1'b0, 1'b0, 8'd0, 0, 1, 0, 0, 8'd1);
        step("b0_idle", 1'b0, 1'b0, 8'd0, 0, 0, 1, 0, 8'd1);

        // 4: start+stop together starts; stop in third en cycle aborts; stop in GAP/IDLE ignored
        step("ab_first", 1'b1, 1'b1, 8'd10, 1, 1, 0, 0, 8'd1);
        step("ab_on2", 1'b0, 1'b0, 8'd10, 1, 1, 0, 0, 8'd2);
        step("ab_on3", 1'b0, 1'b0, 8'd10, 1, 1, 0, 0, 8'd3);
        step("ab_stop", 1'b0, 1'b1, 8'd10, 0, 1, 0, 0, 8'd3);
        step("ab_gap2", 1'b0, 1'b1, 8'd10, 0, 1, 0, 0, 8'd3);
        step("ab_idle", 1'b0, 1'b1, 8'd10, 0, 0, 1, 0, 8'd3);
        step("ab_idle_stop", 1'b0, 1'b0, 8'd10, 0, 0, 1, 0, 8'd3);

        // 4b: stop on the final ON cycle is an abort (no done)
        step("fs_first", 1'b1, 1'b0, 8'd2, 1, 1, 0, 0, 8'd1);
        step("fs_on2", 1'b0, 1'b0, 8'd2, 1, 1, 0, 0, 8'd2);
        step("fs_stop", 1'b0, 1'b1, 8'd2, 0, 1, 0, 0, 8'd2);
        step("fs_gap2", 1'b0, 1'b0, 8'd2, 0, 1, 0, 0, 8'd2);
        step("fs_idle", 1'b0, 1'b0, 8'd2, 0, 0, 1, 0, 8'd2);

        // 5: reset on the second en cycle, then full settle repeats with no done
        step("rm_first", 1'b1, 1'b0, 8'd5, 1, 1, 0, 0, 8'd1);
        step("rm_on2", 1'b0, 1'b0, 8'd5, 1, 1, 0, 0, 8'd2);
        rst = 1'b0;
        step("rm_reset", 1'b0, 1'b0, 8'd5, 0, 0, 0, 0, 8'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step("rm_settle", 1'b1, 1'b0, 8'd5, 0, 0, 0, 0, 8'd0);
        step("rm_ready", 1'b0, 1'b0, 8'd5, 0, 0, 1, 0, 8'd0);

        // 6: maximum length, on_cnt must reach 255 without wrapping
        step("b255_first", 1'b1, 1'b0, 8'd255, 1, 1, 0, 0, 8'd1);
        for (int i = 2; i <= 255; i++) step("b255_on", 1'b0, 1'b0, 8'd3, 1, 1, 0, 0, 8'(i));
        step("b255_done", 1'b0, 1'b0, 8'd3, 0, 1, 0, 1, 8'd255);
        step("b255_gap2", 1'b0, 1'b0, 8'd3, 0, 1, 0, 0, 8'd255);
        step("b255_idle", 1'b0, 1'b0, 8'd3, 0, 0, 1, 0, 8'd255);
        step("b255_hold", 1'b0, 1'b0, 8'd3, 0, 0, 1, 0, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
